// File: rtl/sensor_conditioner_if.sv
// Detector/light/call bundle between the raw detector side and the conditioner.
interface sensor_conditioner_if;
  logic       raw_ew_str;
  logic       raw_ew_left;
  logic       raw_ns;
  logic [1:0] ew_str_light;
  logic [1:0] ew_left_light;
  logic [1:0] ns_light;
  logic       ew_str_sensor;
  logic       ew_left_sensor;
  logic       ns_sensor;
  logic [2:0] fault;

  modport master (
    output raw_ew_str, raw_ew_left, raw_ns,
    output ew_str_light, ew_left_light, ns_light,
    input  ew_str_sensor, ew_left_sensor, ns_sensor, fault
  );

  modport slave (
    input  raw_ew_str, raw_ew_left, raw_ns,
    input  ew_str_light, ew_left_light, ns_light,
    output ew_str_sensor, ew_left_sensor, ns_sensor, fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Detector front end: sync, debounce, call memory and stuck-detector recall per lane,
// feeding the traffic light controller's sensor inputs.
module sc_lane #(
  parameter int DEB_CYCLES   = 3,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  input  logic [1:0] light,
  output logic       sensor,
  output logic       fault
);
  localparam logic [3:0]  DEB_M1   = 4'(DEB_CYCLES - 1);
  localparam logic [15:0] STUCK    = 16'(STUCK_CYCLES);
  localparam logic [15:0] STUCK_M1 = 16'(STUCK_CYCLES - 1);

  logic        sync1, sync2, filt, filt_nxt, call_mem, f;
  logic [3:0]  deb_cnt, deb_nxt;
  logic [15:0] high_cnt;
  logic        green;

  assign green = (light == 2'b10);

  always_comb begin
    filt_nxt = filt;
    deb_nxt  = '0;
    if (sync2 != filt) begin
      if (deb_cnt == DEB_M1) filt_nxt = sync2;
      else                   deb_nxt  = deb_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt     <= 1'b0;
      deb_cnt  <= '0;
      call_mem <= 1'b0;
      high_cnt <= '0;
      f        <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      filt    <= filt_nxt;
      deb_cnt <= deb_nxt;
      if (green)                 call_mem <= 1'b0;
      else if (!filt && filt_nxt) call_mem <= 1'b1;
      // Clear on the edge filt falls so fault and recall drop together with filt.
      if (!filt_nxt) begin
        high_cnt <= '0;
        f        <= 1'b0;
      end else if (filt) begin
        if (high_cnt < STUCK)     high_cnt <= high_cnt + 16'd1;
        if (high_cnt >= STUCK_M1) f        <= 1'b1;
      end
    end
  end

  assign sensor = filt | call_mem | f;
  assign fault  = f;
endmodule

module sensor_conditioner #(
  parameter int DEB_CYCLES   = 3,
  parameter int STUCK_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  sensor_conditioner_if.slave bus
);
  localparam int NUM_LANES = 3;

  // Lane order {ns, ew_left, ew_str} matches the fault vector.
  logic [NUM_LANES-1:0]      raw, sensor, fault;
  logic [NUM_LANES-1:0][1:0] light;

  assign raw   = {bus.raw_ns, bus.raw_ew_left, bus.raw_ew_str};
  assign light = {bus.ns_light, bus.ew_left_light, bus.ew_str_light};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sc_lane #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw[i]),
      .light  (light[i]),
      .sensor (sensor[i]),
      .fault  (fault[i])
    );
  end

  assign bus.ew_str_sensor  = sensor[0];
  assign bus.ew_left_sensor = sensor[1];
  assign bus.ns_sensor      = sensor[2];
  assign bus.fault          = fault;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomized + directed bench for sensor_conditioner against a lane-level reference model.
module tb_sensor_conditioner;
  localparam int DEB   = 3;
  localparam int STUCK = 16;
  localparam logic [5:0] ALL_RED = 6'b00_00_00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sensor_conditioner_if bus();

  sensor_conditioner #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, lane order {ns, ew_left, ew_str}
  logic m_s1[3], m_s2[3], m_filt[3], m_call[3];
  int   m_streak[3], m_hlen[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the behavioural rules.
  task automatic model_step(input logic rst, input logic [2:0] raw, input logic [5:0] lt);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_call[i] = 0;
        m_streak[i] = 0; m_hlen[i] = 0;
      end else begin
        logic prev, s;
        prev = m_filt[i];
        s    = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        if (s != m_filt[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DEB) begin m_filt[i] = s; m_streak[i] = 0; end
        end else m_streak[i] = 0;
        if (lt[2*i +: 2] == 2'b10)     m_call[i] = 0;
        else if (!prev && m_filt[i])   m_call[i] = 1;
        // cycles filt has been high, counting the cycle after the rise edge as 1
        m_hlen[i] = m_filt[i] ? ((m_hlen[i] < 100000) ? m_hlen[i] + 1 : m_hlen[i]) : 0;
      end
    end
  endtask

  function automatic logic [2:0] exp_fault();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = m_filt[i] && (m_hlen[i] > STUCK);
    return r;
  endfunction

  function automatic logic [2:0] exp_sensor();
    logic [2:0] r, fl;
    fl = exp_fault();
    for (int i = 0; i < 3; i++) r[i] = m_filt[i] | m_call[i] | fl[i];
    return r;
  endfunction

  function automatic logic [2:0] got_sensor();
    return {bus.ns_sensor, bus.ew_left_sensor, bus.ew_str_sensor};
  endfunction

  // Called at a negedge: drive, take one rising edge, check at the next negedge.
  task automatic tick(input logic rst, input logic [2:0] raw, input logic [5:0] lt);
    reset             = rst;
    bus.raw_ew_str    = raw[0];
    bus.raw_ew_left   = raw[1];
    bus.raw_ns        = raw[2];
    bus.ew_str_light  = lt[1:0];
    bus.ew_left_light = lt[3:2];
    bus.ns_light      = lt[5:4];
    @(posedge clk);
    model_step(rst, raw, lt);
    @(negedge clk);
    chk("sensor", {29'd0, got_sensor()}, {29'd0, exp_sensor()});
    chk("fault",  {29'd0, bus.fault},    {29'd0, exp_fault()});
  endtask

  task automatic do_reset(input int n, input logic [2:0] raw);
    for (int k = 0; k < n; k++) tick(1'b1, raw, ALL_RED);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [2:0] r_raw;
    logic [5:0] r_lt;
    int hold[3];

    reset = 1'b1;
    bus.raw_ew_str = 0; bus.raw_ew_left = 0; bus.raw_ns = 0;
    bus.ew_str_light = 0; bus.ew_left_light = 0; bus.ns_light = 0;
    @(negedge clk);

    // Reset with raw held high, then measure release latency
    do_reset(2, 3'b001);
    chk("rst_sensor", {29'd0, got_sensor()}, 32'd0);
    chk("rst_fault",  {29'd0, bus.fault},    32'd0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick(1'b0, 3'b001, ALL_RED);
      if (bus.ew_str_sensor) lat = k;
    end
    chk("latency", lat, 2 + DEB);

    // Glitch rejection on ns
    do_reset(2, 3'b000);
    seen = 0;
    for (int k = 0; k < 22; k++) begin
      tick(1'b0, (k < 2) ? 3'b100 : 3'b000, ALL_RED);
      if (bus.ns_sensor) seen = 1;
    end
    chk("glitch", {31'd0, seen}, 32'd0);

    // Call memory on ew_left: held after filt falls, cleared by one green
    do_reset(2, 3'b000);
    for (int k = 0; k < 6; k++) tick(1'b0, 3'b010, ALL_RED);
    for (int k = 0; k < 10; k++) tick(1'b0, 3'b000, ALL_RED);
    chk("call_hold", {31'd0, bus.ew_left_sensor}, 32'd1);
    tick(1'b0, 3'b000, 6'b00_10_00);
    chk("call_clear", {31'd0, bus.ew_left_sensor}, 32'd0);
    for (int k = 0; k < 5; k++) tick(1'b0, 3'b000, ALL_RED);
    chk("call_stay0", {31'd0, bus.ew_left_sensor}, 32'd0);

    // Served lane: ns green throughout
    do_reset(2, 3'b000);
    for (int k = 0; k < 10; k++) tick(1'b0, 3'b100, 6'b10_00_00);
    for (int k = 0; k < 10; k++) tick(1'b0, 3'b000, 6'b10_00_00);
    chk("served_idle", {31'd0, bus.ns_sensor}, 32'd0);

    // Filt rise coincides with green: clear wins
    do_reset(2, 3'b000);
    for (int k = 1; k <= 5; k++) tick(1'b0, 3'b001, (k == 5) ? 6'b00_00_10 : ALL_RED);
    chk("simul_filt", {31'd0, bus.ew_str_sensor}, 32'd1);
    for (int k = 0; k < 10; k++) tick(1'b0, 3'b000, ALL_RED);
    chk("simul_nocall", {31'd0, bus.ew_str_sensor}, 32'd0);

    // Stuck ns detector with cycling light
    do_reset(2, 3'b000);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 3'b100, {(k % 3 == 0) ? 2'b10 : (k % 3 == 1) ? 2'b01 : 2'b00, 4'b0000});
      if (bus.fault[2] && lat == 0) lat = k;
    end
    chk("stuck_edge", lat, 2 + DEB + STUCK);
    for (int k = 0; k < 10; k++) tick(1'b0, 3'b000, ALL_RED);
    chk("stuck_release", {29'd0, bus.fault}, 32'd0);

    // Randomized run
    r_raw = 0; r_lt = 0;
    for (int i = 0; i < 3; i++) hold[i] = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          r_raw[i] = ~r_raw[i];
          hold[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 7);
        end
        if ($urandom_range(0, 5) == 0) r_lt[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      tick($urandom_range(0, 299) == 0, r_raw, r_lt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front-end stage that sits directly upstream of traffic_light_controller1.
- Takes the three raw vehicle-detector inputs (e-w straight, e-w left, n-s). Synchronizes and debounces each one.
- Adds per-lane call memory, so a short vehicle pulse is not lost before its lane goes green.
- Flags detectors stuck high and forces a permanent call on those lanes.
- Outputs drive the controller's ew_str_sensor, ew_left_sensor and ns_sensor directly. The controller's light outputs are fed back in to clear call memory.

Parameters:
- DEB_CYCLES, 3: consecutive differing samples required before the filtered level changes (range 1..15).
- STUCK_CYCLES, 1024: consecutive filtered-high cycles before a lane is declared stuck (range 2..65535).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- raw_ew_str  in  1  asynchronous detector, e-w straight lane
- raw_ew_left  in  1  asynchronous detector, e-w left-turn lane
- raw_ns  in  1  asynchronous detector, n-s lane
- ew_str_light  in  2  controller output fed back (colors: red=00, yellow=01, green=10)
- ew_left_light  in  2  controller output fed back (colors)
- ns_light  in  2  controller output fed back (colors)
- ew_str_sensor  out  1  conditioned call, e-w straight
- ew_left_sensor  out  1  conditioned call, e-w left
- ns_sensor  out  1  conditioned call, n-s
- fault  out  3  stuck-detector flags {ns, ew_left, ew_str}

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk.
- Lane independence: three identical, independent lane slices. Each slice has the following pipeline.
- Synchronizer:
  - Two flops: sync1 <= raw, then sync2 <= sync1.
- Debounce:
  - State is filt (1 bit) and deb_cnt (4 bits).
  - On each edge where sync2 != filt: if deb_cnt == DEB_CYCLES-1, then filt <= sync2 and deb_cnt <= 0; otherwise deb_cnt++.
  - On each edge where sync2 == filt: deb_cnt <= 0.
  - A clean raw step is visible on filt after edge number 2+DEB_CYCLES, counting the first edge that samples the new raw value as edge 1. Default is 5 edges.
  - Any raw pulse shorter than DEB_CYCLES cycles never reaches filt.
- Call memory (call_mem):
  - Clear: on any edge where the lane light == green, call_mem <= 0.
  - Set: otherwise, on an edge where filt goes 0->1 and the lane light != green, call_mem <= 1.
  - Clear has priority over set when both occur on the same edge.
  - Yellow and red both count as not-green.
  - Light code 11 is treated as not-green.
- Stuck detection:
  - State is high_cnt (16 bits, saturating at STUCK_CYCLES) and fault bit f.
  - On each edge with filt == 1: high_cnt++ (saturating), and f <= 1 when high_cnt reaches STUCK_CYCLES.
  - On each edge with filt == 0: high_cnt <= 0 and f <= 0.
- Output:
  - sensor = filt | call_mem | f. This is combinational from registers, with no extra register stage.
  - A stuck lane therefore always calls (fail-safe recall) until its detector releases.
- Reset:
  - While reset is high at an edge, every sync, filt, deb_cnt, call_mem, high_cnt and f clears to 0.
  - All sensors and fault read 0 from the first reset edge onward.
  - Reset asserted mid-debounce or mid-call discards the pending state.
  - After release, raw levels held high re-enter through the full 2+DEB_CYCLES latency.
- No combinational path from raw_* or *_light inputs to any output.

Test Plan:
- Reset/latency: raw_ew_str=1 held through 2 reset cycles, then reset=0 -> ew_str_sensor=0 during reset; rises exactly on the 5th edge after release (DEB_CYCLES=3); fault=000 throughout.
- Glitch reject: raw_ns=1 for 2 cycles then 0, ns_light=red -> ns_sensor stays 0 for 20 cycles.
- Call memory: ew_left_light=red, raw_ew_left=1 for 6 cycles then 0 -> ew_left_sensor rises at edge 5 and stays 1 after filt falls. Drive ew_left_light=green for one cycle -> ew_left_sensor=0 on the following edge and stays 0 when the light returns to red.
- Served lane: ns_light=green throughout, raw_ns=1 for 10 cycles -> ns_sensor rises at edge 5, falls 5 edges after raw falls, no residual call.
- Simultaneous set/clear: arrange the filt 0->1 edge to coincide with ew_str_light=green, then return the light to red and raw to 0 -> call_mem never set; ew_str_sensor drops with filt.
- Stuck detector: STUCK_CYCLES=16, raw_ns held 1 with ns_light cycling green/yellow/red -> fault[2]=1 on the 16th edge after filt rise, ns_sensor=1 continuously. Drop raw_ns -> fault[2] clears and ns_sensor falls together on the filt-fall edge (unless a call_mem is pending).
